// File: rtl/ofdm_rx_pack24to32.sv
// Repacks the RX core's 24-bit decoded-bit stream into dense little-endian
// 32-bit words, with frame flush (zero-padded, tagged last) and a word counter.
module ofdm_rx_pack24to32 #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   din_valid,
  input  logic [23:0]            din_bits,
  output logic                   din_ready,
  input  logic                   flush,
  input  logic                   cnt_clr,
  output logic                   dout_valid,
  output logic [31:0]            dout_data,
  output logic [2:0]             dout_nbytes,
  output logic                   dout_last,
  input  logic                   dout_ready,
  output logic                   flush_done,
  output logic [COUNT_WIDTH-1:0] word_count
);

  // Encoding equals the number of residue bytes held in the accumulator.
  typedef enum logic [1:0] {
    RES_0 = 2'd0,
    RES_1 = 2'd1,
    RES_2 = 2'd2,
    RES_3 = 2'd3
  } res_e;

  res_e                   res_q,        res_d;
  logic [23:0]            acc_q,        acc_d;
  logic                   pend_q,       pend_d;
  logic                   dout_valid_q, dout_valid_d;
  logic [31:0]            dout_data_q,  dout_data_d;
  logic [2:0]             dout_nbytes_q, dout_nbytes_d;
  logic                   dout_last_q,  dout_last_d;
  logic                   flush_done_q, flush_done_d;
  logic [COUNT_WIDTH-1:0] word_count_q, word_count_d;

  logic        out_free_s;
  logic        din_ready_s;
  logic        accept_s;
  logic        resolve_s;
  logic        load_s;
  logic [31:0] ld_data_s;
  logic [2:0]  ld_nbytes_s;
  logic        ld_last_s;

  // Residue FSM: input packing, flush resolution and pending-flush tracking.
  always_comb begin
    res_d       = res_q;
    acc_d       = acc_q;
    pend_d      = pend_q;
    resolve_s   = 1'b0;
    load_s      = 1'b0;
    ld_data_s   = 32'h0000_0000;
    ld_nbytes_s = 3'd0;
    ld_last_s   = 1'b0;

    out_free_s  = !dout_valid_q || dout_ready;
    din_ready_s = out_free_s && !pend_q;
    accept_s    = din_valid && din_ready_s;

    if (accept_s) begin
      case (res_q)
        RES_0: begin
          acc_d = din_bits;
          res_d = RES_3;
        end
        RES_3: begin
          load_s      = 1'b1;
          ld_data_s   = {din_bits[7:0], acc_q[23:0]};
          ld_nbytes_s = 3'd4;
          acc_d       = {8'h00, din_bits[23:8]};
          res_d       = RES_2;
        end
        RES_2: begin
          load_s      = 1'b1;
          ld_data_s   = {din_bits[15:0], acc_q[15:0]};
          ld_nbytes_s = 3'd4;
          acc_d       = {16'h0000, din_bits[23:16]};
          res_d       = RES_1;
        end
        RES_1: begin
          load_s      = 1'b1;
          ld_data_s   = {din_bits[23:0], acc_q[7:0]};
          ld_nbytes_s = 3'd4;
          acc_d       = 24'h00_0000;
          res_d       = RES_0;
        end
        default: begin
          acc_d = 24'h00_0000;
          res_d = RES_0;
        end
      endcase
    end else if (pend_q && out_free_s) begin
      // Unused accumulator bytes are always kept zero, so acc is already padded.
      resolve_s = 1'b1;
      if (res_q != RES_0) begin
        load_s      = 1'b1;
        ld_data_s   = {8'h00, acc_q};
        ld_nbytes_s = {1'b0, res_q};
        ld_last_s   = 1'b1;
      end else begin
        load_s = 1'b0;
      end
      acc_d = 24'h00_0000;
      res_d = RES_0;
    end else begin
      res_d = res_q;
    end

    // A flush arriving while one is already pending is deliberately dropped.
    if (pend_q) begin
      pend_d = !resolve_s;
    end else begin
      pend_d = flush;
    end
  end

  // Output register, flush_done pulse and saturating word counter.
  always_comb begin
    dout_valid_d  = dout_valid_q;
    dout_data_d   = dout_data_q;
    dout_nbytes_d = dout_nbytes_q;
    dout_last_d   = dout_last_q;
    flush_done_d  = resolve_s;
    word_count_d  = word_count_q;

    if (load_s) begin
      dout_valid_d  = 1'b1;
      dout_data_d   = ld_data_s;
      dout_nbytes_d = ld_nbytes_s;
      dout_last_d   = ld_last_s;
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
    end else begin
      dout_valid_d = dout_valid_q;
    end

    if (cnt_clr) begin
      word_count_d = {COUNT_WIDTH{1'b0}};
    end else if (dout_valid_q && dout_ready && (word_count_q != {COUNT_WIDTH{1'b1}})) begin
      word_count_d = word_count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      word_count_d = word_count_q;
    end
  end

  // State registers, cleared asynchronously so a mid-frame reset drops everything.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_q         <= RES_0;
      acc_q         <= 24'h00_0000;
      pend_q        <= 1'b0;
      dout_valid_q  <= 1'b0;
      dout_data_q   <= 32'h0000_0000;
      dout_nbytes_q <= 3'd0;
      dout_last_q   <= 1'b0;
      flush_done_q  <= 1'b0;
      word_count_q  <= {COUNT_WIDTH{1'b0}};
    end else begin
      res_q         <= res_d;
      acc_q         <= acc_d;
      pend_q        <= pend_d;
      dout_valid_q  <= dout_valid_d;
      dout_data_q   <= dout_data_d;
      dout_nbytes_q <= dout_nbytes_d;
      dout_last_q   <= dout_last_d;
      flush_done_q  <= flush_done_d;
      word_count_q  <= word_count_d;
    end
  end

  assign din_ready   = din_ready_s;
  assign dout_valid  = dout_valid_q;
  assign dout_data   = dout_data_q;
  assign dout_nbytes = dout_nbytes_q;
  assign dout_last   = dout_last_q;
  assign flush_done  = flush_done_q;
  assign word_count  = word_count_q;

endmodule

// File: tb/tb_ofdm_rx_pack24to32.sv
// Directed bench for ofdm_rx_pack24to32: packing, flush, backpressure,
// counter saturation/clear and asynchronous reset.
module tb_ofdm_rx_pack24to32;

  logic        clk;
  logic        rstn;
  logic        din_valid;
  logic [23:0] din_bits;
  logic        din_ready;
  logic        flush;
  logic        cnt_clr;
  logic        dout_valid;
  logic [31:0] dout_data;
  logic [2:0]  dout_nbytes;
  logic        dout_last;
  logic        dout_ready;
  logic        flush_done;
  logic [15:0] word_count;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  bit mon_en = 1'b1;
  logic [35:0] mon_q[$];
  logic [7:0]  exp_bytes[$];

  ofdm_rx_pack24to32 #(.COUNT_WIDTH(16)) dut (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .din_bits(din_bits),
    .din_ready(din_ready), .flush(flush), .cnt_clr(cnt_clr),
    .dout_valid(dout_valid), .dout_data(dout_data), .dout_nbytes(dout_nbytes),
    .dout_last(dout_last), .dout_ready(dout_ready), .flush_done(flush_done),
    .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted output word as {last, nbytes, data}.
  always @(negedge clk) begin
    if (mon_en && rstn && dout_valid && dout_ready) mon_q.push_back({dout_last, dout_nbytes, dout_data});
    if (rstn && flush_done) fd_cnt++;
  end

  task automatic do_reset();
    rstn = 1'b0; din_valid = 1'b0; din_bits = 24'h0; flush = 1'b0;
    cnt_clr = 1'b0; dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    mon_q.delete(); exp_bytes.delete(); fd_cnt = 0;
  endtask

  task automatic send(input logic [23:0] w);
    bit ok = 1'b0;
    din_valid = 1'b1; din_bits = w;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (din_ready) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: din_ready never rose for word %h", w);
    end else begin
      exp_bytes.push_back(w[7:0]); exp_bytes.push_back(w[15:8]); exp_bytes.push_back(w[23:16]);
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; din_valid = 1'b0; din_bits = 24'h0; flush = 1'b0;
    cnt_clr = 1'b0; dout_ready = 1'b0;
    #3;
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
    checks++; if (dout_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", dout_data); end
    checks++; if (dout_nbytes !== 3'd0) begin errors++; $display("FAIL reset_nbytes: got %0d want 0", dout_nbytes); end
    checks++; if (dout_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", dout_last); end
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
    checks++; if (word_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h want 0", word_count); end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready: got %b want 1", din_ready); end
  endtask

  task automatic test_packing();
    logic [35:0] exp [3];
    exp[0] = {1'b0, 3'd4, 32'h44332211};
    exp[1] = {1'b0, 3'd4, 32'h88776655};
    exp[2] = {1'b0, 3'd4, 32'hCCBBAA99};
    do_reset();
    send(24'h332211); send(24'h665544); send(24'h998877); send(24'hCCBBAA);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (mon_q.size() != 3) begin errors++; $display("FAIL pack_nwords: got %0d want 3", mon_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= mon_q.size() || mon_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL pack_word%0d: got %h want %h", i, (i < mon_q.size()) ? mon_q[i] : 36'h0, exp[i]);
      end
    end
    checks++; if (word_count !== 16'd3) begin errors++; $display("FAIL pack_count: got %0d want 3", word_count); end
  endtask

  task automatic test_partial_flush();
    do_reset();
    send(24'h332211); send(24'h665544);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL pflush_pending_ready: got %b want 0", din_ready); end
    @(posedge clk); @(negedge clk);
    checks++; if (flush_done !== 1'b1) begin errors++; $display("FAIL pflush_done_pulse: got %b want 1", flush_done); end
    checks++; if (dout_valid !== 1'b1 || dout_data !== 32'h00006655 || dout_nbytes !== 3'd2 || dout_last !== 1'b1) begin
      errors++; $display("FAIL pflush_word: got v=%b %h n=%0d l=%b want v=1 00006655 n=2 l=1", dout_valid, dout_data, dout_nbytes, dout_last);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL pflush_done_count: got %0d want 1", fd_cnt); end
    checks++; if (mon_q.size() != 2) begin errors++; $display("FAIL pflush_nwords: got %0d want 2", mon_q.size()); end
    else begin
      checks++; if (mon_q[0] !== {1'b0, 3'd4, 32'h44332211}) begin errors++; $display("FAIL pflush_first: got %h want 0444332211", mon_q[0]); end
      checks++; if (mon_q[1] !== {1'b1, 3'd2, 32'h00006655}) begin errors++; $display("FAIL pflush_second: got %h want a00006655", mon_q[1]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] got_bytes[$];
    int nlast;
    bit done;
    do_reset();
    send(24'h332211); send(24'h665544);
    dout_ready = 1'b0;
    din_valid = 1'b1; din_bits = 24'h998877;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL bp_din_ready cyc%0d: got %b want 0", i, din_ready); end
      checks++; if (dout_valid !== 1'b1 || dout_data !== 32'h44332211) begin
        errors++; $display("FAIL bp_hold cyc%0d: got v=%b %h want v=1 44332211", i, dout_valid, dout_data);
      end
      @(posedge clk); #1;
    end
    dout_ready = 1'b1;
    send(24'h998877);
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) send(24'($urandom()));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          if (!done) dout_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    dout_ready = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    nlast = 0;
    foreach (mon_q[k]) begin
      if (mon_q[k][35]) nlast++;
      for (int b = 0; b < int'(mon_q[k][34:32]); b++) got_bytes.push_back(mon_q[k][8*b +: 8]);
    end
    checks++; if (got_bytes.size() != exp_bytes.size()) begin
      errors++; $display("FAIL bp_byte_total: got %0d want %0d", got_bytes.size(), exp_bytes.size());
    end
    for (int k = 0; k < exp_bytes.size() && k < got_bytes.size(); k++) begin
      checks++; if (got_bytes[k] !== exp_bytes[k]) begin
        errors++; $display("FAIL bp_byte%0d: got %h want %h", k, got_bytes[k], exp_bytes[k]);
      end
    end
    checks++; if (nlast != 1 || mon_q.size() == 0 || mon_q[mon_q.size()-1][35] !== 1'b1) begin
      errors++; $display("FAIL bp_last_tag: got %0d last words want 1 on final word", nlast);
    end
  endtask

  task automatic test_flush_r0();
    do_reset();
    din_valid = 1'b1; din_bits = 24'hAABBCC; flush = 1'b1;
    @(negedge clk);
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL fr0_ready: got %b want 1", din_ready); end
    @(posedge clk); #1 din_valid = 1'b0; flush = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (mon_q.size() != 1 || mon_q[0] !== {1'b1, 3'd3, 32'h00AABBCC}) begin
      errors++; $display("FAIL fr0_word: got %0d words first %h want 1 word b00AABBCC", mon_q.size(), (mon_q.size() > 0) ? mon_q[0] : 36'h0);
    end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL fr0_done1: got %0d want 1", fd_cnt); end
    mon_q.delete();
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (mon_q.size() != 0) begin errors++; $display("FAIL fr0_empty_word: got %0d words want 0", mon_q.size()); end
    checks++; if (fd_cnt != 2) begin errors++; $display("FAIL fr0_done2: got %0d want 2", fd_cnt); end
  endtask

  task automatic test_counter();
    do_reset();
    mon_en = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 87380; i++) begin
      din_bits = 24'(i);
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (word_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_reach: got %h want ffff", word_count); end
    #1 din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din_bits = 24'(i);
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (word_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_saturate: got %h want ffff", word_count); end
    #1 din_valid = 1'b1; din_bits = 24'h111111;
    @(posedge clk); #1 din_bits = 24'h222222;
    @(posedge clk); #1 din_valid = 1'b0; cnt_clr = 1'b1;
    @(negedge clk);
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL cnt_clr_setup: got valid %b want 1", dout_valid); end
    @(posedge clk); #1 cnt_clr = 1'b0;
    @(negedge clk);
    checks++; if (word_count !== 16'h0) begin errors++; $display("FAIL cnt_clr_priority: got %h want 0", word_count); end
    mon_en = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    send(24'h332211); send(24'h665544); send(24'h998877); send(24'hCCBBAA);
    send(24'h111111); send(24'h222222);
    dout_ready = 1'b0;
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    checks++; if (dout_valid !== 1'b0 || dout_data !== 32'h0 || dout_nbytes !== 3'd0 || dout_last !== 1'b0) begin
      errors++; $display("FAIL areset_out: got v=%b %h n=%0d l=%b want all 0", dout_valid, dout_data, dout_nbytes, dout_last);
    end
    checks++; if (word_count !== 16'h0 || flush_done !== 1'b0) begin
      errors++; $display("FAIL areset_status: got cnt=%h fd=%b want 0 0", word_count, flush_done);
    end
    @(negedge clk); #1 rstn = 1'b1; dout_ready = 1'b1;
    mon_q.delete();
    @(posedge clk); #1;
    send(24'h030201); send(24'h060504);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (mon_q.size() < 1 || mon_q[0] !== {1'b0, 3'd4, 32'h04030201}) begin
      errors++; $display("FAIL areset_resume: got %0d words first %h want 0404030201", mon_q.size(), (mon_q.size() > 0) ? mon_q[0] : 36'h0);
    end
  endtask

  initial begin
    test_reset();
    test_packing();
    test_partial_flush();
    test_backpressure();
    test_flush_r0();
    test_async_reset();
    test_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofdm_rx_pack24to32.md
Name: ofdm_rx_pack24to32

Overview:
- Downstream neighbour of the OFDM RX core. Sits in the sample-clock domain, between the RX core's 24-bit decoded-bit output stream and the 32-bit data FIFO that the AXI register interface drains.
- Repacks a stream of 24-bit words into dense little-endian 32-bit words: four inputs produce three outputs.
- Supports a frame flush that emits any partial word, zero-padded, and tags it as last.
- Keeps a saturating count of emitted words for status readback.

Parameters:
- COUNT_WIDTH, 16, width of the emitted-word counter.

Ports:
- clk  in  1  sample-rate clock; same clock as the RX core.
- rstn  in  1  asynchronous, active-low reset.
- din_valid  in  1  input word valid.
- din_bits  in  24  input word; bits[7:0] is the first byte in stream order.
- din_ready  out  1  input accepted when din_valid && din_ready.
- flush  in  1  single-cycle pulse: close the current frame.
- cnt_clr  in  1  synchronous clear of word_count.
- dout_valid  out  1  output word valid.
- dout_data  out  32  packed output word.
- dout_nbytes  out  3  number of valid bytes in dout_data, 1..4.
- dout_last  out  1  word is the final word of a flushed frame.
- dout_ready  in  1  downstream accept.
- flush_done  out  1  one-cycle pulse when a flush completes.
- word_count  out  COUNT_WIDTH  saturating count of accepted output words.

Behaviour:
- Reset (rstn low, asynchronous):
  - residue count r=0, accumulator=0, flush_pending=0.
  - dout_valid=0, dout_data=0, dout_nbytes=0, dout_last=0.
  - flush_done=0, word_count=0.
- Output register: a single stage. It is free when dout_valid=0, or when dout_valid && dout_ready in the same cycle.
- din_ready = output register free && !flush_pending. This is combinational from registered state and dout_ready.
- Residue state machine, r in {0,3,2,1} bytes held in a 24-bit accumulator. Byte order is little-endian: new bytes are appended above the residue.
  - r=0, accept: acc=din; r->3; no output.
  - r=3, accept: emit {din[7:0],acc[23:0]}; acc=din[23:8]; r->2.
  - r=2, accept: emit {din[15:0],acc[15:0]}; acc=din[23:16]; r->1.
  - r=1, accept: emit {din[23:0],acc[7:0]}; r->0.
  - An emit loads the output register on the accepting edge. dout_valid is high the next cycle, with dout_nbytes=4 and dout_last=0. Latency from the completing input to valid output is 1 cycle.
- Handshake:
  - dout_data, dout_nbytes and dout_last hold stable while dout_valid && !dout_ready.
  - dout_valid drops the cycle after acceptance unless a new word is loaded on that edge.
  - With dout_ready held high, throughput is one input per cycle.
- word_count:
  - Increments on each dout_valid && dout_ready and saturates at all-ones.
  - cnt_clr has priority over a same-cycle increment and forces 0.
- Flush:
  - flush sets flush_pending. An input accepted in the same cycle as flush is processed first; the flush applies to the state after that input.
  - While flush_pending, the flush resolves on the first cycle the output register is free:
    - r>0: load acc zero-padded to 32 bits, dout_nbytes=r, dout_last=1; r->0; pulse flush_done; clear pending.
    - r=0: emit nothing; pulse flush_done; clear pending. The last full word already emitted is not retro-tagged.
  - flush while flush_pending is already high is ignored (pending stays set; only one flush_done is produced).
- Output register never overwritten while valid and not accepted.
- No data loss: din_ready low is the only backpressure mechanism. The block never drops an input.
- Reset asserted mid-frame discards residue and any pending output immediately.

Test Plan:
- Packing: with dout_ready=1, send 0x332211, 0x665544, 0x998877, 0xCCBBAA back to back. Required: 0x44332211, 0x88776655, 0xCCBBAA99, each with nbytes=4 and last=0, and word_count=3.
- Partial flush: send 0x332211, 0x665544, then pulse flush. Required:
  - 0x44332211 with nbytes=4.
  - Then 0x00006655 with nbytes=2 and last=1.
  - flush_done pulses once.
  - din_ready is low for the pending cycles.
- Backpressure: hold dout_ready=0 after the first output word. Required:
  - dout_data stays 0x44332211.
  - din_ready=0 from the following cycle.
  - Releasing ready resumes the stream with no lost or duplicated bytes across a 400-word random sequence checked against a byte-level scoreboard.
- Flush coincident with input at r=0: send 0xAABBCC together with flush. Required: one word 0x00AABBCC with nbytes=3 and last=1. A flush at r=0 with no input produces flush_done only and no dout_valid.
- Counter: preload via 65535+ accepted words. Required: word_count holds 0xFFFF. A cnt_clr asserted together with an accept yields 0.
- Async reset: drop rstn with r=2 and dout_valid=1 and dout_ready=0. Required: all outputs read 0 in the same cycle; after release, the first two inputs 0x030201 and 0x060504 give 0x04030201.
